// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB bus arbiter.
//   arb_state_t      : sequencing states of the arbiter FSM
//   ERR_DATA_DEFAULT : read data handed back when a transfer is aborted
//   FAULT_CNT_W      : width of the saturating timeout counter
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
    localparam int          FAULT_CNT_W      = 8;

endpackage

// File: rtl/apb_arb_watchdog.sv
// Transfer watchdog: counts cycles while enabled and flags the last
// permitted cycle.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   clr   : clear the count (takes priority over en)
//   en    : count this cycle
//   hit   : high while enabled and the count equals TIMEOUT_CYC - 1
module apb_arb_watchdog #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign hit = en && (cnt == LIMIT);

endmodule

// File: rtl/apb_bus_arbiter.sv
// Two-requester front end for a single APB master.
// Requester 0 (CPU) and requester 1 (DMA/debug) share the master's
// transfer/ready interface; one transfer is in flight at a time, and a
// watchdog aborts transfers whose peripheral never answers.
//
// Handshake: a requester raises sN_transfer with stable write/addr/wdata
// and holds it until sN_ready pulses for one cycle; it must drop transfer
// in the following cycle. On the master side m_transfer is a one-cycle
// start pulse and m_ready a one-cycle completion pulse; m_ready is only
// honoured while a transfer is outstanding.
//
// Ports:
//   PCLK, PRESET          : clock, synchronous active-low reset
//   s0_* / s1_*           : requester interfaces (transfer, write, addr,
//                           wdata in; rdata, ready, err out)
//   m_*                   : APB master command/response interface
//   grant                 : one-hot current owner, 00 when idle
//   fault_cnt             : saturating number of timed-out transfers
//   dbg_state             : current FSM state
module apb_bus_arbiter
    import apb_arb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                TIMEOUT_CYC = 1024,
    parameter int                FIXED_PRIO  = 0,
    parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   s0_transfer,
    input  logic                   s0_write,
    input  logic [ADDR_W-1:0]      s0_addr,
    input  logic [DATA_W-1:0]      s0_wdata,
    output logic [DATA_W-1:0]      s0_rdata,
    output logic                   s0_ready,
    output logic                   s0_err,
    input  logic                   s1_transfer,
    input  logic                   s1_write,
    input  logic [ADDR_W-1:0]      s1_addr,
    input  logic [DATA_W-1:0]      s1_wdata,
    output logic [DATA_W-1:0]      s1_rdata,
    output logic                   s1_ready,
    output logic                   s1_err,
    output logic                   m_transfer,
    output logic                   m_write,
    output logic [ADDR_W-1:0]      m_addr,
    output logic [DATA_W-1:0]      m_wdata,
    input  logic [DATA_W-1:0]      m_rdata,
    input  logic                   m_ready,
    output logic [1:0]             grant,
    output logic [FAULT_CNT_W-1:0] fault_cnt,
    output logic [1:0]             dbg_state
);

    arb_state_t             state, state_n;
    logic                   owner;       // 0 = requester 0, 1 = requester 1
    logic                   last_grant;
    logic [1:0]             grant_q;
    logic                   write_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic                   err_q;
    logic [DATA_W-1:0]      rdata0_q, rdata1_q;
    logic [FAULT_CNT_W-1:0] fault_q;

    logic win_vld;
    logic win_id;
    logic wd_hit;

    apb_arb_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk  (PCLK),
        .rst_n(PRESET),
        .clr  (state != WAIT),
        .en   (state == WAIT),
        .hit  (wd_hit)
    );

    always_comb begin
        state_n = state;
        win_vld = 1'b0;
        win_id  = 1'b0;
        case (state)
            IDLE: begin
                if (s0_transfer && s1_transfer) begin
                    win_vld = 1'b1;
                    // Round-robin hands the bus to whoever did not have it last.
                    win_id  = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
                end else if (s0_transfer) begin
                    win_vld = 1'b1;
                    win_id  = 1'b0;
                end else if (s1_transfer) begin
                    win_vld = 1'b1;
                    win_id  = 1'b1;
                end
                if (win_vld) begin
                    state_n = ISSUE;
                end
            end
            ISSUE:   state_n = WAIT;
            // A ready on the timeout cycle still completes normally.
            WAIT:    if (m_ready || wd_hit) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            grant_q    <= 2'b00;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            fault_q    <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && win_vld) begin
                owner      <= win_id;
                last_grant <= win_id;
                grant_q    <= win_id ? 2'b10 : 2'b01;
                write_q    <= win_id ? s1_write : s0_write;
                addr_q     <= win_id ? s1_addr  : s0_addr;
                wdata_q    <= win_id ? s1_wdata : s0_wdata;
            end
            if (state == WAIT) begin
                if (m_ready) begin
                    err_q <= 1'b0;
                    if (owner) rdata1_q <= m_rdata;
                    else       rdata0_q <= m_rdata;
                end else if (wd_hit) begin
                    err_q <= 1'b1;
                    if (owner) rdata1_q <= ERR_DATA;
                    else       rdata0_q <= ERR_DATA;
                    if (fault_q != '1) begin
                        fault_q <= fault_q + FAULT_CNT_W'(1);
                    end
                end
            end
            if (state == RESP) begin
                grant_q <= 2'b00;
            end
        end
    end

    assign m_transfer = (state == ISSUE);
    assign m_write    = write_q;
    assign m_addr     = addr_q;
    assign m_wdata    = wdata_q;
    assign s0_ready   = (state == RESP) && !owner;
    assign s1_ready   = (state == RESP) &&  owner;
    assign s0_err     = s0_ready && err_q;
    assign s1_err     = s1_ready && err_q;
    assign s0_rdata   = rdata0_q;
    assign s1_rdata   = rdata1_q;
    assign grant      = grant_q;
    assign fault_cnt  = fault_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_apb_bus_arbiter.sv
module tb_apb_bus_arbiter;
  import apb_arb_pkg::*;

  localparam int T = 16;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  // ---------------- clock / reset ----------------
  logic PCLK = 1'b0;
  logic PRESET = 1'b0;
  always #5 PCLK = ~PCLK;

  // ---------------- main DUT (round-robin) ----------------
  logic        s0_transfer = 0, s0_write = 0, s1_transfer = 0, s1_write = 0;
  logic [31:0] s0_addr = 0, s0_wdata = 0, s1_addr = 0, s1_wdata = 0;
  logic [31:0] s0_rdata, s1_rdata;
  logic        s0_ready, s0_err, s1_ready, s1_err;
  logic        m_transfer, m_write;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata = 0;
  logic        m_ready = 0;
  logic [1:0]  grant, dbg_state;
  logic [7:0]  fault_cnt;

  apb_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(T), .FIXED_PRIO(0), .ERR_DATA(ERRD)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .s0_transfer(s0_transfer), .s0_write(s0_write), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
    .s0_rdata(s0_rdata), .s0_ready(s0_ready), .s0_err(s0_err),
    .s1_transfer(s1_transfer), .s1_write(s1_write), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
    .s1_rdata(s1_rdata), .s1_ready(s1_ready), .s1_err(s1_err),
    .m_transfer(m_transfer), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .grant(grant), .fault_cnt(fault_cnt), .dbg_state(dbg_state)
  );

  // ---------------- second DUT (fixed priority) ----------------
  logic        fp_s0_transfer = 0, fp_s1_transfer = 0;
  logic [31:0] fp_s0_rdata, fp_s1_rdata;
  logic        fp_s0_ready, fp_s0_err, fp_s1_ready, fp_s1_err;
  logic        fp_m_transfer, fp_m_write;
  logic [31:0] fp_m_addr, fp_m_wdata;
  logic        fp_m_ready = 0;
  logic [1:0]  fp_grant, fp_dbg_state;
  logic [7:0]  fp_fault_cnt;

  apb_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(T), .FIXED_PRIO(1), .ERR_DATA(ERRD)) dut_fp (
    .PCLK(PCLK), .PRESET(PRESET),
    .s0_transfer(fp_s0_transfer), .s0_write(1'b0), .s0_addr(32'h10), .s0_wdata(32'h0),
    .s0_rdata(fp_s0_rdata), .s0_ready(fp_s0_ready), .s0_err(fp_s0_err),
    .s1_transfer(fp_s1_transfer), .s1_write(1'b1), .s1_addr(32'h20), .s1_wdata(32'h1),
    .s1_rdata(fp_s1_rdata), .s1_ready(fp_s1_ready), .s1_err(fp_s1_err),
    .m_transfer(fp_m_transfer), .m_write(fp_m_write), .m_addr(fp_m_addr), .m_wdata(fp_m_wdata),
    .m_rdata(32'h55), .m_ready(fp_m_ready),
    .grant(fp_grant), .fault_cnt(fp_fault_cnt), .dbg_state(fp_dbg_state)
  );

  // Peripheral behind the second DUT answers in the first WAIT cycle.
  always @(posedge PCLK) fp_m_ready <= fp_m_transfer;

  // ---------------- bookkeeping ----------------
  int vectors = 0;
  int miscompares = 0;
  int exp_fault = 0;
  int model_last = 1;
  bit abort = 0;

  typedef struct packed {
    logic        id;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  delay;   // WAIT cycle carrying m_ready; 0 = never answer
    logic [31:0] rdata;
  } mst_t;

  mst_t        mst_q[$];
  logic [33:0] exp_q[$];  // {id, err, rdata}

  logic        rq_write[2];
  logic [31:0] rq_addr[2], rq_wdata[2], rq_rdata[2];
  int          rq_delay[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_err(input int d);
    return (d == 0) || (d > T);
  endfunction

  // ---------------- master model + command-side checks ----------------
  initial begin
    mst_t e;
    int   lim;
    bit   stable;
    forever begin
      @(negedge PCLK);
      if (m_transfer && !abort) begin
        if (mst_q.size() == 0) begin
          check("unexpected_m_transfer", 1, 0);
        end else begin
          e = mst_q.pop_front();
          check("m_addr", m_addr, e.addr);
          check("m_write", m_write, e.write);
          check("m_wdata", m_wdata, e.wdata);
          check("grant_owner", grant, e.id ? 2'b10 : 2'b01);
          lim = is_err(e.delay) ? T + 1 : int'(e.delay);
          stable = 1;
          for (int c = 1; c <= lim; c++) begin
            @(negedge PCLK);
            if (abort) break;
            if (c == 1) check("m_transfer_pulse", m_transfer, 0);
            if (c <= T && (m_addr !== e.addr || m_write !== e.write || m_wdata !== e.wdata)) stable = 0;
            if (c == T + 1) check("timeout_ready", e.id ? s1_ready : s0_ready, 1);
            if (c == int'(e.delay)) begin
              m_ready = 1;
              m_rdata = e.rdata;
              @(negedge PCLK);
              m_ready = 0;
              m_rdata = $urandom;
              if (!abort && c <= T) check("ready_after_m_ready", e.id ? s1_ready : s0_ready, 1);
            end
          end
          if (!abort) check("m_fields_stable", stable, 1);
        end
      end
    end
  end

  // ---------------- response monitor / scoreboard ----------------
  initial begin
    logic [33:0] e;
    bit          pend = 0;
    logic        pend_id;
    logic [31:0] pend_rd;
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        if (pend) begin
          check("grant_idle_after_resp", grant, 2'b00);
          check("rdata_hold", pend_id ? s1_rdata : s0_rdata, pend_rd);
          pend = 0;
        end
        if (s0_ready || s1_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ready", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("resp_id", {s1_ready, s0_ready}, e[33] ? 2'b10 : 2'b01);
            check("resp_rdata", e[33] ? s1_rdata : s0_rdata, e[31:0]);
            check("resp_err", e[33] ? s1_err : s0_err, e[32]);
            check("other_err", e[33] ? s0_err : s1_err, 0);
            if (e[32] && exp_fault < 255) exp_fault++;
            check("fault_cnt", fault_cnt, exp_fault);
            pend = 1;
            pend_id = e[33];
            pend_rd = e[31:0];
          end
        end
      end else begin
        pend = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input int id, input bit p);
    if (!p) return;
    for (int i = 0; i < 300; i++) begin
      @(negedge PCLK);
      if ((id == 0) ? s0_ready : s1_ready) begin
        if (id == 0) s0_transfer = 0; else s1_transfer = 0;
        return;
      end
    end
    check((id == 0) ? "s0_ready_wait_expired" : "s1_ready_wait_expired", 0, 1);
    if (id == 0) s0_transfer = 0; else s1_transfer = 0;
  endtask

  // Issues one contention round from an idle bus using rq_* fields.
  task automatic run_round(input bit p0, input bit p1);
    int   order[$];
    int   first;
    mst_t m;
    bit   er;
    repeat (2 + $urandom_range(0, 2)) @(negedge PCLK);
    if (p0 && p1) begin
      first = (model_last == 0) ? 1 : 0;
      order = '{first, 1 - first};
    end else begin
      order = '{p1 ? 1 : 0};
    end
    foreach (order[k]) begin
      m.id    = order[k][0];
      m.write = rq_write[order[k]];
      m.addr  = rq_addr[order[k]];
      m.wdata = rq_wdata[order[k]];
      m.delay = 8'(rq_delay[order[k]]);
      m.rdata = rq_rdata[order[k]];
      mst_q.push_back(m);
      er = is_err(rq_delay[order[k]]);
      exp_q.push_back({m.id, er, er ? ERRD : m.rdata});
    end
    model_last = order[order.size() - 1];
    s0_transfer = p0; s0_write = rq_write[0]; s0_addr = rq_addr[0]; s0_wdata = rq_wdata[0];
    s1_transfer = p1; s1_write = rq_write[1]; s1_addr = rq_addr[1]; s1_wdata = rq_wdata[1];
    fork
      wait_ready(0, p0);
      wait_ready(1, p1);
    join
  endtask

  task automatic set_req(input int id, input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input int dl, input logic [31:0] rd);
    rq_write[id] = w; rq_addr[id] = a; rq_wdata[id] = wd; rq_delay[id] = dl; rq_rdata[id] = rd;
  endtask

  function automatic int rand_delay();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) return $urandom_range(1, 6);
    if (r == 6) return T - 1;
    if (r == 7) return T;
    if (r == 8) return T + 1;
    return 0;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    repeat (3) @(negedge PCLK);
    check("rst_state", dbg_state, IDLE);
    check("rst_grant", grant, 2'b00);
    check("rst_outputs", {m_transfer, m_write, s0_ready, s1_ready, s0_err, s1_err}, 0);
    check("rst_data", {m_addr, m_wdata, s0_rdata, s1_rdata}, 0);
    check("rst_fault", fault_cnt, 0);
    PRESET = 1;

    // Single read from s0.
    set_req(0, 0, 32'h1000_0004, 32'h0, 2, 32'h0000_00A5);
    run_round(1, 0);
    // Write from s1 with a slow peripheral.
    set_req(1, 1, 32'h1000_2000, 32'h1234_5678, 10, 32'h0BAD_0001);
    run_round(0, 1);
    // Timeout on s0 with a stray late ready, then a normal s1 transfer.
    set_req(0, 0, 32'h1000_0008, 32'h0, T + 1, 32'h1111_2222);
    run_round(1, 0);
    set_req(1, 0, 32'h1000_200C, 32'h0, 3, 32'h3333_4444);
    run_round(0, 1);
    // Ready exactly on the timeout boundary.
    set_req(0, 0, 32'h1000_0010, 32'h0, T, 32'h0000_0077);
    run_round(1, 0);
    // Continuous contention.
    for (int i = 0; i < 2; i++) begin
      set_req(0, 0, 32'h2000_0000 + i, 32'h0, 1, 32'hA000_0000 + i);
      set_req(1, 1, 32'h3000_0000 + i, 32'hB000_0000 + i, 2, 32'hC000_0000 + i);
      run_round(1, 1);
    end

    // Randomized rounds.
    for (int i = 0; i < 40; i++) begin
      int p;
      p = $urandom_range(1, 3);
      for (int r = 0; r < 2; r++)
        set_req(r, 1'($urandom_range(0, 1)), $urandom, $urandom, rand_delay(), $urandom);
      run_round(p[0], p[1]);
    end

    // Reset in the middle of WAIT.
    begin
      mst_t m;
      repeat (2) @(negedge PCLK);
      m = '{id: 1'b0, write: 1'b1, addr: 32'h1000_0040, wdata: 32'h5A5A_5A5A, delay: 8'd0, rdata: 32'h0};
      mst_q.push_back(m);
      s0_transfer = 1; s0_write = 1; s0_addr = 32'h1000_0040; s0_wdata = 32'h5A5A_5A5A;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge PCLK);
        if (m_transfer) seen = 1;
      end
      check("reset_test_issue_seen", seen, 1);
      repeat (3) @(negedge PCLK);
      abort = 1;
      PRESET = 0;
      s0_transfer = 0;
      @(negedge PCLK);
      check("midrst_state", dbg_state, IDLE);
      check("midrst_grant", grant, 2'b00);
      check("midrst_outputs", {m_transfer, m_write, s0_ready, s1_ready, s0_err, s1_err}, 0);
      check("midrst_data", {m_addr, m_wdata, s0_rdata, s1_rdata}, 0);
      check("midrst_fault", fault_cnt, 0);
      exp_fault = 0;
      model_last = 1;
      PRESET = 1;
      @(negedge PCLK);
      check("midrst_no_ready", {s0_ready, s1_ready}, 0);
      abort = 0;
    end
    set_req(0, 0, 32'h1000_0050, 32'h0, 1, 32'h0000_0101);
    set_req(1, 0, 32'h1000_2050, 32'h0, 1, 32'h0000_0202);
    run_round(1, 1);

    // Fixed priority: s0 wins contention even right after holding the bus.
    begin
      bit got;
      fp_s0_transfer = 1;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge PCLK);
        if (fp_s0_ready) got = 1;
      end
      fp_s0_transfer = 0;
      check("fp_solo_done", got, 1);
      repeat (2) @(negedge PCLK);
      fp_s0_transfer = 1;
      fp_s1_transfer = 1;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge PCLK);
        if (fp_s0_ready || fp_s1_ready) begin
          got = 1;
          check("fp_first_winner", {fp_s1_ready, fp_s0_ready}, 2'b01);
        end
      end
      check("fp_first_done", got, 1);
      fp_s0_transfer = 0;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge PCLK);
        if (fp_s1_ready) got = 1;
      end
      fp_s1_transfer = 0;
      check("fp_second_done", got, 1);
    end

    repeat (4) @(negedge PCLK);
    check("exp_q_drained", exp_q.size(), 0);
    check("mst_q_drained", mst_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit: simulation did not finish");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "time limit");
  end

endmodule
